result_tile_writer: RTL

RESULT_TILE_WRITER -- requirements
Module: result_tile_writer

---
 rtl/result_tile_writer_pkg.sv | 17 +
 rtl/tile_fifo2.sv | 33 +++
 rtl/result_tile_writer.sv | 90 +++++++++
 3 files changed

// File: rtl/result_tile_writer_pkg.sv
// result_tile_writer_pkg: tile types and constants shared by the PE and the result tile writer.
package result_tile_writer_pkg;
  localparam int TILE_N6 = 6;
  localparam int TILE_N4 = 4;
  typedef logic signed [0:5][0:5][15:0] tile_t;
  typedef enum logic {SZ_6X6 = 1'b0, SZ_4X4 = 1'b1} size_t;
  typedef struct packed {
    tile_t       tile;
    logic [7:0]  od;
    logic [8:0]  x;
    logic [8:0]  y;
    size_t       sz;
  } entry_t;
  function automatic logic [2:0] tile_n(input size_t s);
    return (s == SZ_4X4) ? 3'(TILE_N4) : 3'(TILE_N6);
  endfunction
endpackage

// File: rtl/tile_fifo2.sv
// tile_fifo2: two-entry FIFO of captured tiles with their od, x, y and size type.
module tile_fifo2
  import result_tile_writer_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);
  entry_t     r_mem [0:1];
  logic       r_wp, r_rp;
  logic [1:0] r_cnt;
  always_ff @(posedge clk)
    if (push) r_mem[r_wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (push) r_wp <= ~r_wp;
      if (pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(push) - 2'(pop);
    end
  end
  assign dout  = r_mem[r_rp];
  assign full  = (r_cnt == 2'd2);
  assign empty = (r_cnt == 2'd0);
endmodule

// File: rtl/result_tile_writer.sv
// result_tile_writer: buffers PE result tiles and writes their in-range elements to memory row-major.
module result_tile_writer
  import result_tile_writer_pkg::*;
#(
  parameter int IMG_H  = 512,
  parameter int IMG_W  = 512,
  parameter int ADDR_W = 26
) (
  input  logic               clk,
  input  logic               reset,
  input  tile_t              res_tile_i,
  input  logic               res_valid_i,
  input  logic [7:0]         res_od_i,
  input  logic [8:0]         res_x_i,
  input  logic [8:0]         res_y_i,
  input  logic               res_size_type_i,
  output logic               mem_wr_en_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic signed [15:0] mem_data_o,
  input  logic               mem_ready_i,
  output logic               busy_o,
  output logic               tile_done_o,
  output logic               overflow_o
);
  localparam logic [9:0] H = 10'(IMG_H);
  localparam logic [9:0] W = 10'(IMG_W);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t      r_state;
  logic [2:0]  r_r, r_c;
  logic        r_done, r_ovf;
  entry_t      w_din, w_head;
  logic        w_full, w_empty, w_push, w_pop, w_acc, w_wr, w_none, w_last_col, w_last;
  logic [2:0]  w_n, w_nr, w_nc;
  logic [9:0]  w_hx, w_hy, w_xr, w_yc;
  assign w_din = '{tile: res_tile_i, od: res_od_i, x: res_x_i, y: res_y_i, sz: size_t'(res_size_type_i)};
  tile_fifo2 u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );
  // The in-range region is a rectangle, so clipping reduces to a per-tile row/column count.
  always_comb begin
    w_n        = tile_n(w_head.sz);
    w_hx       = {1'b0, w_head.x};
    w_hy       = {1'b0, w_head.y};
    w_nr       = (w_hx >= H) ? 3'd0 : ((H - w_hx) < 10'(w_n)) ? 3'(H - w_hx) : w_n;
    w_nc       = (w_hy >= W) ? 3'd0 : ((W - w_hy) < 10'(w_n)) ? 3'(W - w_hy) : w_n;
    w_none     = (w_nr == 3'd0) || (w_nc == 3'd0);
    w_wr       = (r_state == WRITE) && !w_none;
    w_acc      = w_wr && mem_ready_i;
    w_last_col = (r_c == w_nc - 3'd1);
    w_last     = w_last_col && (r_r == w_nr - 3'd1);
    w_pop      = (r_state == WRITE) && (w_none || (w_acc && w_last));
    w_push     = res_valid_i && (!w_full || w_pop);
    w_xr       = w_hx + 10'(r_r);
    w_yc       = w_hy + 10'(r_c);
    mem_wr_en_o = w_wr;
    mem_addr_o  = w_wr ? ADDR_W'(w_head.od) * ADDR_W'(IMG_H * IMG_W) + ADDR_W'(w_xr) * ADDR_W'(IMG_W) + ADDR_W'(w_yc) : '0;
    mem_data_o  = w_wr ? w_head.tile[r_r][r_c] : '0;
  end
  // WRITE tracks whether the FIFO holds a tile after this edge, so a fresh tile writes one cycle after capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_r     <= 3'd0;
      r_c     <= 3'd0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= (w_push || w_full || (!w_empty && !w_pop)) ? WRITE : IDLE;
      r_done  <= w_pop;
      r_ovf   <= r_ovf || (res_valid_i && !w_push);
      if (w_pop) begin
        r_r <= 3'd0;
        r_c <= 3'd0;
      end else if (w_acc) begin
        r_c <= w_last_col ? 3'd0 : r_c + 3'd1;
        r_r <= w_last_col ? r_r + 3'd1 : r_r;
      end
    end
  end
  assign busy_o      = !w_empty || (r_state == WRITE);
  assign tile_done_o = r_done;
  assign overflow_o  = r_ovf;
endmodule
